// File: rtl/jh_pkg.sv
// jh_pkg: shared JH core types, widths and helpers
package jh_pkg;
  localparam int IOSIZE_DEF = 16;
  typedef enum logic [1:0] {IDLE, BUSY, HOLDOFF} state_t;
  function automatic int wd_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction
  function automatic logic [2:0] oh2idx(input logic [7:0] v);
    logic [2:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) if (v[i]) r = 3'(i);
    return r;
  endfunction
endpackage

// File: rtl/jh_rr_pick.sv
// jh_rr_pick: round-robin one-hot picker, search starts just after last owner
module jh_rr_pick #(
  parameter int NREQ = 2,
  localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] elig,
  input  logic [IW-1:0]   last,
  output logic [NREQ-1:0] win
);
  logic [IW-1:0] j;
  always_comb begin
    win = '0;
    j = '0;
    for (int i = 1; i <= NREQ; i++) begin
      j = IW'((int'(last) + i) % NREQ);
      if (win == '0 && elig[j]) win[j] = 1'b1;
    end
  end
endmodule

// File: rtl/jh_core_arbiter.sv
// jh_core_arbiter: shares one JH core between NREQ requesters, whole-job grants
module jh_core_arbiter import jh_pkg::*; #(
  parameter int NREQ = 2,
  parameter int IOSIZE = IOSIZE_DEF,
  parameter int IDLE_TIMEOUT = 1024
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req,
  output logic [NREQ-1:0]        gnt,
  input  logic [NREQ-1:0]        init_i,
  input  logic [NREQ-1:0]        load_i,
  input  logic [NREQ-1:0]        fetch_i,
  input  logic [NREQ*IOSIZE-1:0] idata_i,
  output logic [NREQ-1:0]        ack_o,
  output logic [IOSIZE-1:0]      odata_o,
  output logic [NREQ-1:0]        err_o,
  output logic                   core_init,
  output logic                   core_load,
  output logic                   core_fetch,
  output logic [IOSIZE-1:0]      core_idata,
  input  logic                   core_ack,
  input  logic [IOSIZE-1:0]      core_odata
);
  localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1;
  localparam int WW = wd_width(IDLE_TIMEOUT);
  state_t state, nxt;
  logic [IW-1:0] owner, last;
  logic [NREQ-1:0] elig, win, abort;
  logic [WW-1:0] wd;
  logic busy, act, rel, tmo;
  assign busy = state == BUSY;
  assign owner = IW'(oh2idx(8'(gnt)));
  assign elig = req & ~abort;
  assign act = busy && (init_i[owner] || load_i[owner] || fetch_i[owner]);
  assign rel = busy && !req[owner] && !act;
  // a held load/fetch counts as activity, so a pending handshake is never revoked
  assign tmo = busy && !req[owner] == 1'b0 && !act && wd == WW'(IDLE_TIMEOUT - 1);
  assign odata_o = core_odata;
  jh_rr_pick #(.NREQ(NREQ)) u_pick (.elig(elig), .last(last), .win(win));
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  end
  always_comb begin
    nxt = state == IDLE ? (|elig ? BUSY : IDLE) : busy ? (rel || tmo ? HOLDOFF : BUSY) : IDLE;
  end
  always_comb begin
    core_init = busy & init_i[owner];
    core_load = busy & load_i[owner];
    core_fetch = busy & fetch_i[owner];
    core_idata = busy ? idata_i[int'(owner)*IOSIZE +: IOSIZE] : '0;
    ack_o = busy ? gnt & {NREQ{core_ack}} : '0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt <= '0;
      err_o <= '0;
      abort <= '0;
      wd <= '0;
      last <= IW'(NREQ - 1);
    end else begin
      err_o <= tmo ? gnt : '0;
      abort <= (abort | (tmo ? gnt : '0)) & req;
      wd <= busy && !act ? wd + 1'b1 : '0;
      if (state == IDLE && |elig) begin
        gnt <= win;
        last <= IW'(oh2idx(8'(win)));
      end else if (rel || tmo) gnt <= '0;
    end
  end
endmodule

// File: tb/tb_jh_core_arbiter.sv
// tb_jh_core_arbiter: directed pins plus random requesters against a behavioural model
module tb_jh_core_arbiter;
  localparam int NREQ = 2, IOSIZE = 16, TO = 8;
  logic clk = 0, rst_n = 0;
  logic [1:0] req = 0, init_i = 0, load_i = 0, fetch_i = 0, gnt, ack_o, err_o, ack_seen = 0;
  logic [31:0] idata_i = 0;
  logic [15:0] odata_o, core_idata, core_odata = 0;
  logic core_init, core_load, core_fetch, core_ack = 0;
  int checks = 0, failures = 0, acnt = 0, adly = 0;
  bit chk_en = 0;
  int m_owner = -1, m_last = NREQ - 1, m_idle = 0;
  bit m_hold = 0;
  logic [1:0] m_ab = 0, m_err = 0;
  int ph[2], st[2], cnt[2];
  always #5 clk = ~clk;
  jh_core_arbiter #(.NREQ(NREQ), .IOSIZE(IOSIZE), .IDLE_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt), .init_i(init_i), .load_i(load_i),
    .fetch_i(fetch_i), .idata_i(idata_i), .ack_o(ack_o), .odata_o(odata_o), .err_o(err_o),
    .core_init(core_init), .core_load(core_load), .core_fetch(core_fetch),
    .core_idata(core_idata), .core_ack(core_ack), .core_odata(core_odata));
  task automatic check(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s t=%0t actual=%h expected=%h", nm, $time, a, e);
    end
  endtask
  function automatic logic own_bit(input logic [1:0] v);
    return m_owner >= 0 ? v[m_owner] : 1'b0;
  endfunction
  task automatic model_step();
    logic [1:0] e;
    int j;
    bit a;
    e = '0;
    if (!rst_n) begin
      m_owner = -1; m_hold = 0; m_idle = 0; m_last = NREQ - 1; m_ab = '0; m_err = '0;
      return;
    end
    a = own_bit(init_i) | own_bit(load_i) | own_bit(fetch_i);
    if (m_hold) m_hold = 0;
    else if (m_owner < 0) begin
      for (int k = 1; k <= NREQ; k++) begin
        j = (m_last + k) % NREQ;
        if (m_owner < 0 && req[j] && !m_ab[j]) begin m_owner = j; m_last = j; m_idle = 0; end
      end
    end else if (!req[m_owner] && !a) begin m_owner = -1; m_hold = 1; end
    else if (a) m_idle = 0;
    else begin
      m_idle++;
      if (m_idle == TO) begin e[m_owner] = 1; m_ab[m_owner] = 1; m_owner = -1; m_hold = 1; end
    end
    m_ab = m_ab & req;
    m_err = e;
  endtask
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("gnt", 32'(gnt), m_owner >= 0 ? 32'(1 << m_owner) : 32'd0);
      check("err_o", 32'(err_o), 32'(m_err));
      check("core_init", 32'(core_init), 32'(own_bit(init_i)));
      check("core_load", 32'(core_load), 32'(own_bit(load_i)));
      check("core_fetch", 32'(core_fetch), 32'(own_bit(fetch_i)));
      check("core_idata", 32'(core_idata), m_owner >= 0 ? 32'(16'(idata_i >> (16 * m_owner))) : 32'd0);
      check("ack_o", 32'(ack_o), m_owner >= 0 && core_ack ? 32'(1 << m_owner) : 32'd0);
      check("odata_o", 32'(odata_o), 32'(core_odata));
    end
  end
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask
  task automatic core_step();
    #1;
    if (core_load | core_fetch) begin
      acnt++;
      core_ack = acnt > adly;
      if (core_ack) begin acnt = 0; adly = $urandom_range(0, 2); end
    end else begin
      acnt = 0;
      core_ack = 0;
    end
    core_odata = 16'($urandom);
    #1 ack_seen = ack_o;
  endtask
  function automatic int gap();
    return $urandom_range(0, 9) == 0 ? 11 : $urandom_range(0, 2);
  endfunction
  initial begin
    int k;
    logic [1:0] errs;
    req = 2'b11;
    tick();
    chk_en = 1;
    tick();
    tick();
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_ctl", 32'({core_init, core_load, core_fetch}), 32'd0);
    rst_n = 1;
    tick();
    check("first_gnt", 32'(gnt), 32'b01);
    for (k = 1; k <= 20; k++) begin
      tick();
      if (err_o != 0) break;
    end
    check("to_cycle", 32'(k), 32'd8);
    check("to_err", 32'(err_o), 32'b01);
    check("to_gnt", 32'(gnt), 32'd0);
    tick();
    tick();
    check("to_next", 32'(gnt), 32'b10);
    req = 2'b01;
    for (int i = 0; i < 6; i++) tick();
    check("abort_hold", 32'(gnt), 32'd0);
    req = 2'b00;
    tick();
    req = 2'b01;
    tick();
    check("regrant0", 32'(gnt), 32'b01);
    errs = 0;
    for (int i = 0; i < 100; i++) begin
      fetch_i[0] = i % 7 == 0;
      tick();
      errs |= err_o;
    end
    check("activity_no_err", 32'(errs), 32'd0);
    check("activity_gnt", 32'(gnt), 32'b01);
    fetch_i = 0;
    req = 0;
    tick(); tick(); tick();
    req = 2'b11;
    tick();
    check("rr_gnt1", 32'(gnt), 32'b10);
    load_i[1] = 1;
    idata_i[31:16] = 16'h0003;
    tick();
    rst_n = 0;
    tick();
    check("midrst_gnt", 32'(gnt), 32'd0);
    check("midrst_load", 32'(core_load), 32'd0);
    check("midrst_err", 32'(err_o), 32'd0);
    rst_n = 1;
    load_i = 0;
    tick();
    check("midrst_regrant", 32'(gnt), 32'b01);
    req = 0;
    for (int i = 0; i < 2; i++) begin ph[i] = 0; st[i] = 0; cnt[i] = $urandom_range(0, 3); end
    for (int c = 0; c < 3000; c++) begin
      tick();
      rst_n = !(c % 1000 == 500 || c % 1000 == 501);
      for (int i = 0; i < 2; i++) begin
        case (ph[i])
          0: if (cnt[i] > 0) cnt[i]--; else begin req[i] = 1; ph[i] = 1; end
          1: if (gnt[i]) begin ph[i] = 2; st[i] = 0; cnt[i] = $urandom_range(0, 2); end
          default:
            if (!gnt[i]) begin
              req[i] = 0; init_i[i] = 0; load_i[i] = 0; fetch_i[i] = 0;
              ph[i] = 0; cnt[i] = $urandom_range(1, 4);
            end else if (load_i[i] | fetch_i[i]) begin
              if (ack_seen[i]) begin
                load_i[i] = 0; fetch_i[i] = 0; st[i]++; cnt[i] = gap();
                if (st[i] == 6) req[i] = 0;
              end
            end else if (init_i[i]) begin
              init_i[i] = 0; st[i]++; cnt[i] = gap();
            end else if (st[i] >= 6 || cnt[i] > 0) begin
              if (cnt[i] > 0) cnt[i]--;
            end else if (st[i] == 0) init_i[i] = 1;
            else if (st[i] < 5) begin
              load_i[i] = 1;
              idata_i[i*16 +: 16] = 16'(st[i]);
              if ($urandom_range(0, 3) == 0) req[i] = 0;
            end else fetch_i[i] = 1;
        endcase
      end
      core_step();
    end
    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/jh_core_arbiter.md
# jh_core_arbiter

Shares one JH hash core (init/load/fetch/ack, 16-bit idata/odata) between NREQ requesters. Grants the core for a whole hash job, from INIT through the final FETCH. Muxes the granted requester's controls onto the core and routes ack back to it. A watchdog revokes a grant that goes idle. Sits directly between the requester blocks and the core top.

## Interface
- NREQ, 2: number of requesters (2..8)
- IOSIZE, 16: core data width
- IDLE_TIMEOUT, 1024: idle cycles before a grant is revoked (≥2)
- clk  in  1  core clock
- rst_n  in  1  synchronous, active-low reset
- req  in  NREQ  per-requester core request, level
- gnt  out  NREQ  one-hot-or-zero grant
- init_i / load_i / fetch_i  in  NREQ each  per-requester core controls
- idata_i  in  NREQ*IOSIZE  per-requester load data; slice i = bits [i*IOSIZE +: IOSIZE]
- ack_o  out  NREQ  core ack routed to the granted requester only
- odata_o  out  IOSIZE  core odata broadcast; valid only for the granted requester while ack_o is high
- err_o  out  NREQ  one-cycle pulse on timeout revoke
- core_init / core_load / core_fetch  out  1 each  to core
- core_idata  out  IOSIZE  to core
- core_ack  in  1  from core
- core_odata  in  IOSIZE  from core

## Operation
- FSM states: IDLE, BUSY, HOLDOFF.
- **IDLE**
  - If any eligible req is high, the rr_pick winner is registered into gnt; go to BUSY.
  - Eligible means req high and abort flag clear.
  - Round-robin: search starts at the index after the last granted owner.
- **BUSY**
  - core_init/load/fetch/idata = owner's inputs, combinationally.
  - ack_o[owner] = core_ack; all other ack_o bits are 0.
- **Release (BUSY → HOLDOFF)**
  - Owner drops req with init_i, load_i and fetch_i all low: gnt clears next cycle.
  - req low while any owner control is high: release is deferred until the controls are low. No handshake is cut.
- **Watchdog**
  - Counter of width $clog2(IDLE_TIMEOUT+1).
  - Cleared on grant and on any cycle with owner init|load|fetch high. Otherwise increments.
  - At IDLE_TIMEOUT: gnt clears, err_o[owner] pulses, abort[owner] sets, go to HOLDOFF.
  - abort[i] clears when req[i] is sampled low.
- **HOLDOFF**: exactly one cycle with all core controls and core_idata at 0, then IDLE. This guarantees the core sees controls deasserted between owners.
- No grant (IDLE/HOLDOFF): core controls = 0, core_idata = 0, ack_o = 0.
- Simultaneous requests: exactly one winner. Losers wait; no starvation beyond NREQ-1 jobs.

## Timing
- **Reset** (rst_n low at a clk edge):
  - state = IDLE, gnt = 0, err_o = 0, abort = 0, watchdog = 0.
  - RR pointer = NREQ-1, so requester 0 wins first.
  - Combinational outputs are 0.
  - Reset mid-job drops the grant immediately. No err pulse.
- **Grant latency**: req sampled high at edge n (IDLE) → gnt high after edge n.
- **Handover**: release sampled at edge n → gnt low after n, HOLDOFF during n..n+1, next gnt after edge n+2. Minimum gap between owners is 2 cycles.
- **Control/data path**: combinational, zero latency, both directions. Requesters follow the core handshake: hold load/fetch until ack.
- **Revoke**: err_o and gnt-low both take effect after the edge where the counter reaches IDLE_TIMEOUT.
- **Watchdog with no outstanding handshake**: the timeout never fires while a load/fetch is held, since a held control counts as activity.

## Structure
- jh_pkg: IOSIZE default, state enum (IDLE/BUSY/HOLDOFF), timeout-width function. Shared with the core top and requesters.
- One sub-module: jh_rr_pick.
  - Combinational NREQ-bit round-robin picker.
  - Inputs: eligible vector, last-owner index. Output: one-hot winner.
- Everything else stays in jh_core_arbiter: FSM, muxes, watchdog, abort flags.

## Test plan
- **Reset**: rst_n low 3 cycles with req=2'b11 → gnt=0, core_* = 0. Release → gnt=2'b01 one cycle later.
- **Contention**: req=2'b11 held; each owner does INIT, 4 LOADs of 16'h0001..0004, 1 FETCH, then drops req.
  - Grants must alternate 01,10,01.
  - Two-cycle zero gap with core controls low at each switch.
  - ack_o never high on the non-owner.
- **Deferred release**: owner drops req while load high waiting for ack.
  - gnt stays until core_ack completes and load falls, then HOLDOFF.
- **Timeout**: IDLE_TIMEOUT=8; owner 0 idles after grant.
  - Cycle 8: err_o=2'b01 one cycle, gnt→0.
  - Requester 1 is granted 2 cycles later.
  - Requester 0 is not re-granted until its req drops and rises again.
- **Activity resets the watchdog**: IDLE_TIMEOUT=8; owner pulses fetch every 7 cycles for 100 cycles → no err_o.
- **Mid-job reset**: rst_n low during a LOAD → gnt=0 and core_load=0 next cycle, no err_o. After release, requester 0 is granted first.
